oursring_resp_ppln: RTL
=======================

Name: oursring_resp_ppln

Overview:
Response-direction register slice for the oursring AXI-style interface. It carries the B (write response) and R (read data) channels from the ring-side slave back toward the initiator. It is the counterpart of the request pipeline, which carries AW/W/AR. Each channel gets an independent 2-entry skid buffer, implemented inline, that registers both the forward path (valid/data) and the backward path (ready) with full throughput.

Parameters:
STALL_CNT_W, 16, width of the optional per-channel stall counters (used only when OURSRING_RESP_PPLN_PERF_EN is defined).

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
i_resp_if_bvalid  input  1  upstream B valid
i_resp_if_bready  output  1  upstream B ready
i_resp_if_b  input  $bits(oursring_resp_if_b_t)  upstream B payload
i_resp_if_rvalid  input  1  upstream R valid
i_resp_if_rready  output  1  upstream R ready
i_resp_if_r  input  $bits(oursring_resp_if_r_t)  upstream R payload (includes rlast)
o_resp_if_bvalid  output  1  downstream B valid
o_resp_if_bready  input  1  downstream B ready
o_resp_if_b  output  $bits(oursring_resp_if_b_t)  downstream B payload
o_resp_if_rvalid  output  1  downstream R valid
o_resp_if_rready  input  1  downstream R ready
o_resp_if_r  output  $bits(oursring_resp_if_r_t)  downstream R payload
o_b_stall_cnt  output  STALL_CNT_W  B stall cycles (macro only)
o_r_stall_cnt  output  STALL_CNT_W  R stall cycles (macro only)

Behaviour:
- Payload types come from pygmy_intf_typedef. Single clock domain: clk. Reset: rstn, asynchronous assert, active low.
- Per-channel state: main_vld/main_dat (output register), skid_vld/skid_dat.
- Output mapping: o_*valid = main_vld; o_* payload = main_dat; i_*ready = ~skid_vld. Every output is a flop or the inverse of a flop; there is no combinational path from input to output.
- Transfer rules:
  - push = i_*valid & i_*ready.
  - pop = main_vld & o_*ready.
- Update rules:
  - main empty, push: main <= input. Latency is 1 cycle from accept to o_*valid.
  - main full, pop, skid full: main <= skid, skid cleared. The upstream cannot push in this case because ready is 0.
  - main full, pop, skid empty, push: main <= input (streaming, 1 beat/cycle).
  - main full, pop, skid empty, no push: main_vld <= 0.
  - main full, no pop, push: skid <= input. Ready drops the next cycle.
  - main full, no pop, no push: hold.
- Occupancy never exceeds 2. Accepted beats are delivered in order, with none lost or duplicated.
- While o_*valid=1 and o_*ready=0, the payload and valid are held stable (AXI stability).
- Sustained throughput is 1 beat/cycle with ready=1 on both sides. One downstream stall cycle absorbs one extra beat into skid.
- B and R are fully independent. There is no cross-channel ordering; R burst beats (rlast) pass through unmodified.
- Reset values: main_vld=0, skid_vld=0, data regs=0. Therefore o_*valid=0, o_* payload=0, i_*ready=1. Reset mid-transfer discards buffered beats. The first cycle after deassertion behaves as empty.

Optional Feature:
OURSRING_RESP_PPLN_PERF_EN
- Defined:
  - o_b_stall_cnt and o_r_stall_cnt ports exist.
  - Each increments by 1 every cycle that o_*valid=1 and o_*ready=0.
  - Each saturates at 2^STALL_CNT_W-1.
  - Each resets to 0.
- Undefined: the ports and counters are absent, and the datapath is identical.

Test Plan:
- Streaming: 8 R beats (data 0..7, rlast on beat 7), both readys held 1 -> o_resp_if_rvalid rises 1 cycle after the first accept; 8 consecutive beats in order; i_resp_if_rready stays 1.
- Backpressure: B beats 0xA, 0xB pushed back-to-back with o_resp_if_bready=0 -> i_resp_if_bready=0 from the cycle after the second accept; third beat 0xC held off; on bready=1 the output is 0xA, 0xB, 0xC in order, stable while stalled.
- Simultaneous push/pop with skid full: skid full, pop asserted -> main takes skid; ready returns to 1 next cycle; no beat dropped.
- Channel independence: R stalled 5 cycles while B streams 4 beats -> all 4 B beats delivered on time; R resumes intact.
- Reset mid-operation: rstn asserted with 2 R beats buffered -> o_resp_if_rvalid=0 and i_resp_if_rready=1 immediately (asynchronously); nothing emitted after release.
- PERF_EN: bvalid held with bready=0 for 10 cycles -> o_b_stall_cnt=10; with STALL_CNT_W=4 and a 20-cycle stall -> saturates at 15.

Source files
------------

// File: rtl/oursring_resp_ppln.sv
// rtl/oursring_resp_ppln.sv - B/R response register slice with inline 2-entry skid buffers (opt: OURSRING_RESP_PPLN_PERF_EN)

package pygmy_intf_typedef;
    typedef struct packed {
        logic [3:0]  bid;
        logic [1:0]  bresp;
    } oursring_resp_if_b_t;

    typedef struct packed {
        logic [3:0]  rid;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } oursring_resp_if_r_t;

    localparam int RESP_B_W = $bits(oursring_resp_if_b_t);
    localparam int RESP_R_W = $bits(oursring_resp_if_r_t);
endpackage

module oursring_resp_ppln
    import pygmy_intf_typedef::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_resp_if_bvalid,
    output logic                   i_resp_if_bready,
    input  logic [RESP_B_W-1:0]    i_resp_if_b,
    input  logic                   i_resp_if_rvalid,
    output logic                   i_resp_if_rready,
    input  logic [RESP_R_W-1:0]    i_resp_if_r,
    output logic                   o_resp_if_bvalid,
    input  logic                   o_resp_if_bready,
    output logic [RESP_B_W-1:0]    o_resp_if_b,
    output logic                   o_resp_if_rvalid,
    input  logic                   o_resp_if_rready,
    output logic [RESP_R_W-1:0]    o_resp_if_r
`ifdef OURSRING_RESP_PPLN_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] o_b_stall_cnt,
    output logic [STALL_CNT_W-1:0] o_r_stall_cnt
`endif
);

    logic                b_main_vld, b_skid_vld;
    logic [RESP_B_W-1:0] b_main_dat, b_skid_dat;
    logic                r_main_vld, r_skid_vld;
    logic [RESP_R_W-1:0] r_main_dat, r_skid_dat;
    logic                b_push, b_pop, r_push, r_pop;

    assign b_push = i_resp_if_bvalid & ~b_skid_vld;
    assign b_pop  = b_main_vld & o_resp_if_bready;
    assign r_push = i_resp_if_rvalid & ~r_skid_vld;
    assign r_pop  = r_main_vld & o_resp_if_rready;

    // Skid only fills while main is held; it drains into main before new input is taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b_main_vld <= 1'b0;
            b_main_dat <= '0;
            b_skid_vld <= 1'b0;
            b_skid_dat <= '0;
        end else if (!b_main_vld || b_pop) begin
            if (b_skid_vld) begin
                b_main_vld <= 1'b1;
                b_main_dat <= b_skid_dat;
                b_skid_vld <= 1'b0;
            end else begin
                b_main_vld <= b_push;
                if (b_push) begin
                    b_main_dat <= i_resp_if_b;
                end
            end
        end else if (b_push) begin
            b_skid_vld <= 1'b1;
            b_skid_dat <= i_resp_if_b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_main_vld <= 1'b0;
            r_main_dat <= '0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
        end else if (!r_main_vld || r_pop) begin
            if (r_skid_vld) begin
                r_main_vld <= 1'b1;
                r_main_dat <= r_skid_dat;
                r_skid_vld <= 1'b0;
            end else begin
                r_main_vld <= r_push;
                if (r_push) begin
                    r_main_dat <= i_resp_if_r;
                end
            end
        end else if (r_push) begin
            r_skid_vld <= 1'b1;
            r_skid_dat <= i_resp_if_r;
        end
    end

    assign o_resp_if_bvalid = b_main_vld;
    assign o_resp_if_b      = b_main_dat;
    assign i_resp_if_bready = ~b_skid_vld;
    assign o_resp_if_rvalid = r_main_vld;
    assign o_resp_if_r      = r_main_dat;
    assign i_resp_if_rready = ~r_skid_vld;

`ifdef OURSRING_RESP_PPLN_PERF_EN
    logic [STALL_CNT_W-1:0] b_stall_cnt, r_stall_cnt;

    // Saturating counts of cycles where a beat is presented but not taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b_stall_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (b_main_vld && !o_resp_if_bready && (b_stall_cnt != '1)) begin
                b_stall_cnt <= b_stall_cnt + 1'b1;
            end
            if (r_main_vld && !o_resp_if_rready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_b_stall_cnt = b_stall_cnt;
    assign o_r_stall_cnt = r_stall_cnt;
`endif

endmodule
